// File: rtl/disp_pkg.sv
// Shared constants for the 8-digit multiplexed 7-segment display path.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

    localparam int N_DIGITS = 8;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'b1000000;
    localparam seg_t SEG_1    = 7'b1111001;
    localparam seg_t SEG_2    = 7'b0100100;
    localparam seg_t SEG_3    = 7'b0110000;
    localparam seg_t SEG_4    = 7'b0011001;
    localparam seg_t SEG_5    = 7'b0010010;
    localparam seg_t SEG_6    = 7'b0000010;
    localparam seg_t SEG_7    = 7'b1111000;
    localparam seg_t SEG_8    = 7'b0000000;
    localparam seg_t SEG_9    = 7'b0010000;
    localparam seg_t SEG_DASH = 7'b0111111;
    localparam seg_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment glyph; non-decimal nibbles show a dash.
module bcd_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] digit,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Requests periodic BCD conversions, latches each result on idle rising, and scans it onto
// an 8-digit common-anode display with anti-ghost blanking and optional leading-zero blanking.
module bcd_display_driver
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int BLANK_CYC   = 8,
    parameter int UPDATE_DIV  = 10_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         bcd,
    input  logic                idle,
    input  logic                lz_en,
    input  logic [N_DIGITS-1:0] dp_mask,
    output logic                trigger,
    output logic [N_DIGITS-1:0] an,
    output seg_t                seg,
    output logic                dp
);

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int UW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

    logic [SW-1:0]  slot_cnt;
    logic [UW-1:0]  upd_cnt;
    logic [2:0]     idx;
    logic [31:0]    val_r;
    logic           idle_q;
    logic           pending;

    logic           slot_wrap;
    logic           upd_wrap;
    logic           req;
    logic           fire;
    logic           in_blank;
    logic [3:0]     digits [N_DIGITS];
    logic [3:0]     cur_digit;
    logic [N_DIGITS-1:0] lz_mask;
    logic           zero_run;
    seg_t           glyph;

    assign slot_wrap = (slot_cnt == SW'(REFRESH_DIV - 1));
    assign upd_wrap  = (upd_cnt == UW'(UPDATE_DIV - 1));
    assign in_blank  = (slot_cnt < SW'(BLANK_CYC));

    // A wrap fires directly when the converter is idle, otherwise it waits in pending.
    assign req  = upd_wrap | pending;
    assign fire = req & idle & ~trigger;

    always_comb begin
        for (int i = 0; i < N_DIGITS; i++) begin
            digits[i] = val_r[4*i +: 4];
        end
    end

    assign cur_digit = digits[idx];

    // Scan from the most significant digit down; blanking stops at the first non-zero digit.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (digits[i] == 4'd0);
            lz_mask[i] = lz_en & zero_run & (i != 0);
        end
    end

    bcd_to_7seg u_dec (
        .digit (cur_digit),
        .seg   (glyph)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
            idx      <= '0;
            upd_cnt  <= '0;
            pending  <= 1'b0;
            trigger  <= 1'b0;
            idle_q   <= 1'b1;
            val_r    <= '0;
        end else begin
            idle_q <= idle;
            if (idle && !idle_q) begin
                val_r <= bcd;
            end

            if (slot_wrap) begin
                slot_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            if (upd_wrap) begin
                upd_cnt <= '0;
            end else begin
                upd_cnt <= upd_cnt + 1'b1;
            end

            trigger <= fire;
            pending <= req & ~fire;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (in_blank) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= ~(N_DIGITS'(1) << idx);
            seg <= lz_mask[idx] ? SEG_OFF : glyph;
            dp  <= ~dp_mask[idx];
        end
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver with short timer periods; expected values hand-derived.
module tb_bcd_display_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] bcd;
    logic        idle;
    logic        lz_en;
    logic [7:0]  dp_mask;
    logic        trigger;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    always #5 clk = ~clk;

    bcd_display_driver #(
        .REFRESH_DIV (8),
        .BLANK_CYC   (2),
        .UPDATE_DIV  (40)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bcd     (bcd),
        .idle    (idle),
        .lz_en   (lz_en),
        .dp_mask (dp_mask),
        .trigger (trigger),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_digit(input int d);
        logic [7:0] tgt;
        int n;
        tgt = ~(8'b1 << d);
        n = 0;
        while (an !== tgt && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check_val($sformatf("wait_digit%0d", d), 32'(an), 32'(tgt));
    endtask

    task automatic capture(input logic [31:0] v);
        idle = 1'b0;
        step();
        step();
        bcd  = v;
        idle = 1'b1;
        step();
        step();
        step();
    endtask

    // Starting right after release with val_r=0, lz_en=0, dp_mask=0, idle=1 throughout.
    task automatic scan_from_reset(input string pfx);
        int c, d;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        for (int k = 1; k <= 64; k++) begin
            step();
            c = (k - 1) % 8;
            d = ((k - 1) / 8) % 8;
            exp_an  = (c < 2) ? 8'hFF : ~(8'b1 << d);
            exp_seg = (c < 2) ? 7'h7F : 7'b1000000;
            check_val($sformatf("%s_an_e%0d", pfx, k), 32'(an), 32'(exp_an));
            check_val($sformatf("%s_seg_e%0d", pfx, k), 32'(seg), 32'(exp_seg));
            check_val($sformatf("%s_dp_e%0d", pfx, k), 32'(dp), 32'd1);
            check_val($sformatf("%s_trig_e%0d", pfx, k), 32'(trigger), (k == 40) ? 32'd1 : 32'd0);
        end
    endtask

    logic [6:0] exp_t2 [8] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40, 7'h40};
    logic [6:0] exp_t3a [8] = '{7'h40, 7'h40, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] exp_t3b [8] = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n_trig;

        // 1: reset with random inputs, then the first scan frame and first trigger
        reset_n = 1'b0;
        idle = 1'b1; bcd = '0; lz_en = 1'b0; dp_mask = '0;
        for (int k = 0; k < 6; k++) begin
            idle    = 1'($urandom);
            bcd     = $urandom;
            lz_en   = 1'($urandom);
            dp_mask = 8'($urandom);
            step();
            check_val("rst_an", 32'(an), 32'hFF);
            check_val("rst_seg", 32'(seg), 32'h7F);
            check_val("rst_dp", 32'(dp), 32'd1);
            check_val("rst_trig", 32'(trigger), 32'd0);
        end
        idle = 1'b1; bcd = $urandom; lz_en = 1'b0; dp_mask = '0;
        step();
        reset_n = 1'b1;
        scan_from_reset("t1");

        // 2: capture and per-digit glyphs
        capture(32'h0012_3456);
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            check_val($sformatf("t2_seg_d%0d", d), 32'(seg), 32'(exp_t2[d]));
            check_val($sformatf("t2_dp_d%0d", d), 32'(dp), 32'd1);
        end

        // 3: leading-zero blanking
        lz_en = 1'b1;
        capture(32'h0000_0100);
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            check_val($sformatf("t3a_seg_d%0d", d), 32'(seg), 32'(exp_t3a[d]));
        end
        capture(32'h0000_0000);
        for (int d = 0; d < 8; d++) begin
            wait_digit(d);
            check_val($sformatf("t3b_seg_d%0d", d), 32'(seg), 32'(exp_t3b[d]));
        end

        // 4: deferred trigger across a busy conversion
        n_trig = 0;
        while ((cyc % 40) != 30 && n_trig < 100) begin
            step();
            n_trig++;
        end
        idle = 1'b0;
        w = cyc + 10;
        n_trig = 0;
        while (cyc < w + 14) begin
            step();
            if (trigger) n_trig++;
        end
        check_val("t4_no_trig_busy", 32'(n_trig), 32'd0);
        idle = 1'b1;
        step();
        check_val("t4_deferred_trig", 32'(trigger), 32'd1);
        n_trig = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (trigger) n_trig++;
        end
        check_val("t4_single_trig", 32'(n_trig), 32'd0);

        // 5: invalid nibble and decimal point
        lz_en = 1'b0;
        dp_mask = 8'h80;
        capture(32'hA000_0000);
        wait_digit(6);
        check_val("t5_seg_d6", 32'(seg), 32'h40);
        check_val("t5_dp_d6", 32'(dp), 32'd1);
        wait_digit(7);
        check_val("t5_seg_d7", 32'(seg), 32'h3F);
        check_val("t5_dp_d7", 32'(dp), 32'd0);

        // 6: reset mid-scan
        dp_mask = 8'h00;
        wait_digit(5);
        reset_n = 1'b0;
        #1;
        check_val("t6_an_async", 32'(an), 32'hFF);
        check_val("t6_seg_async", 32'(seg), 32'h7F);
        check_val("t6_trig_async", 32'(trigger), 32'd0);
        step();
        step();
        idle = 1'b1;
        reset_n = 1'b1;
        scan_from_reset("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
